// File: rtl/pwrgood_sequencer.sv
// Power-good sequencer: debounces the supply-good input, then ramps three
// power domains up/down in staged steps; supply loss latches a sticky fault.
module pwrgood_sequencer #(
  parameter int DEBOUNCE_CYCLES = 8,
  parameter int STAGE_DELAY     = 4
) (
  input  logic       CLK,
  input  logic       RESET_B,
  input  logic       EN,
  input  logic       PWR_OK,
  input  logic       CLR_FAULT,
  output logic [2:0] DOM_EN,
  output logic       PG_X,
  output logic       FAULT,
  output logic [2:0] STATE
);

  typedef enum logic [2:0] {
    ST_OFF  = 3'd0,
    ST_DEB  = 3'd1,
    ST_RAMP = 3'd2,
    ST_ON   = 3'd3,
    ST_DOWN = 3'd4,
    ST_FLT  = 3'd5
  } state_e;

  localparam logic [7:0] DEB_LAST = 8'(DEBOUNCE_CYCLES - 1);
  localparam logic [7:0] STG_LAST = 8'(STAGE_DELAY - 1);

  state_e     state, state_n;
  logic [7:0] cnt, cnt_n;
  logic [2:0] dom_n;
  logic       pg_n, flt_n;
  logic       loss;

  always_ff @(posedge CLK or negedge RESET_B) begin
    if (!RESET_B) begin
      state  <= ST_OFF;
      cnt    <= '0;
      DOM_EN <= '0;
      PG_X   <= 1'b0;
      FAULT  <= 1'b0;
    end else begin
      state  <= state_n;
      cnt    <= cnt_n;
      DOM_EN <= dom_n;
      PG_X   <= pg_n;
      FAULT  <= flt_n;
    end
  end

  assign STATE = state;

  // Supply loss while any domain may be powered overrides every other transition.
  assign loss = !PWR_OK && (state == ST_RAMP || state == ST_ON || state == ST_DOWN);

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    dom_n   = DOM_EN;
    pg_n    = PG_X;
    flt_n   = FAULT;
    case (state)
      ST_OFF: begin
        dom_n = '0;
        pg_n  = 1'b0;
        flt_n = 1'b0;
        cnt_n = '0;
        if (EN && PWR_OK) state_n = ST_DEB;
      end
      ST_DEB: begin
        dom_n = '0;
        pg_n  = 1'b0;
        if (!EN) begin
          state_n = ST_OFF;
          cnt_n   = '0;
        end else if (!PWR_OK) begin
          cnt_n = '0;
        end else if (cnt == DEB_LAST) begin
          state_n = ST_RAMP;
          dom_n   = 3'b001;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt + 8'd1;
        end
      end
      ST_RAMP: begin
        if (!EN) begin
          state_n = ST_DOWN;
          pg_n    = 1'b0;
          cnt_n   = '0;
        end else if (cnt == STG_LAST) begin
          cnt_n = '0;
          if (DOM_EN == 3'b111) begin
            state_n = ST_ON;
            pg_n    = 1'b1;
          end else begin
            dom_n = {DOM_EN[1:0], 1'b1};
          end
        end else begin
          cnt_n = cnt + 8'd1;
        end
      end
      ST_ON: begin
        cnt_n = '0;
        if (!EN) begin
          state_n = ST_DOWN;
          pg_n    = 1'b0;
        end else begin
          dom_n = 3'b111;
          pg_n  = 1'b1;
        end
      end
      ST_DOWN: begin
        pg_n = 1'b0;
        if (cnt == STG_LAST) begin
          cnt_n = '0;
          dom_n = DOM_EN >> 1;
          // Clearing bit 0 (nothing above it left) finishes the sequence.
          if (!DOM_EN[1]) state_n = ST_OFF;
        end else begin
          cnt_n = cnt + 8'd1;
        end
      end
      ST_FLT: begin
        dom_n = '0;
        pg_n  = 1'b0;
        flt_n = 1'b1;
        cnt_n = '0;
        if (CLR_FAULT && !EN) begin
          state_n = ST_OFF;
          flt_n   = 1'b0;
        end
      end
      default: begin
        state_n = ST_OFF;
        dom_n   = '0;
        pg_n    = 1'b0;
        flt_n   = 1'b0;
        cnt_n   = '0;
      end
    endcase
    if (loss) begin
      state_n = ST_FLT;
      dom_n   = '0;
      pg_n    = 1'b0;
      flt_n   = 1'b1;
      cnt_n   = '0;
    end
  end

endmodule

// File: tb/tb_pwrgood_sequencer.sv
module tb_pwrgood_sequencer;

  logic       clk, rst_n, en, en2, pwr_ok, clr;
  logic [2:0] dom1, st1, dom2, st2;
  logic       pg1, flt1, pg2, flt2;

  pwrgood_sequencer dut (
    .CLK(clk), .RESET_B(rst_n), .EN(en), .PWR_OK(pwr_ok), .CLR_FAULT(clr),
    .DOM_EN(dom1), .PG_X(pg1), .FAULT(flt1), .STATE(st1)
  );

  pwrgood_sequencer #(.DEBOUNCE_CYCLES(1), .STAGE_DELAY(1)) dut_fast (
    .CLK(clk), .RESET_B(rst_n), .EN(en2), .PWR_OK(pwr_ok), .CLR_FAULT(clr),
    .DOM_EN(dom2), .PG_X(pg2), .FAULT(flt2), .STATE(st2)
  );

  typedef struct {
    int         cyc;
    int         id;
    logic [2:0] st;
    logic [2:0] dom;
    logic       pg;
    logic       flt;
    string      nm;
  } exp_t;

  exp_t       q[$];
  exp_t       e;
  logic [7:0] got, want;
  int         cyc = 0;
  int         n_cmp = 0;
  int         n_bad = 0;
  bit         done = 0;
  bit         fin = 0;
  int         b, t, f, p;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    while (q.size() > 0 && (q[0].cyc <= cyc || done)) begin
      e    = q.pop_front();
      want = {e.st, e.dom, e.pg, e.flt};
      got  = (e.id == 0) ? {st1, dom1, pg1, flt1} : {st2, dom2, pg2, flt2};
      n_cmp++;
      if (e.cyc != cyc || got !== want) begin
        n_bad++;
        $display("FAIL %s (edge %0d, now %0d): got st=%0d dom=%b pg=%b flt=%b, want st=%0d dom=%b pg=%b flt=%b",
                 e.nm, e.cyc, cyc, got[7:5], got[4:2], got[1], got[0],
                 want[7:5], want[4:2], want[1], want[0]);
      end
    end
  end

  initial begin
    #200000;
    if (!fin) begin
      n_bad++;
      $display("FAIL timeout: stimulus did not complete");
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input int c, input int id, input int st, input int dom,
                     input int pg, input int flt, input string nm);
    q.push_back('{c, id, 3'(st), 3'(dom), 1'(pg), 1'(flt), nm});
  endtask

  task automatic now_chk(input int id, input int st, input int dom,
                         input int pg, input int flt, input string nm);
    logic [7:0] g, w;
    w = {3'(st), 3'(dom), 1'(pg), 1'(flt)};
    g = (id == 0) ? {st1, dom1, pg1, flt1} : {st2, dom2, pg2, flt2};
    n_cmp++;
    if (g !== w) begin
      n_bad++;
      $display("FAIL %s (immediate, edge %0d): got %b, want %b", nm, cyc, g, w);
    end
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b0; en2 = 1'b0; pwr_ok = 1'b0; clr = 1'b0;
    #1;
    now_chk(0, 0, 0, 0, 0, "rst_now");
    now_chk(1, 0, 0, 0, 0, "rst_now_fast");
    repeat (2) tick();
    chk(cyc, 0, 0, 0, 0, 0, "rst_hold");
    chk(cyc, 1, 0, 0, 0, 0, "rst_hold_fast");
    tick();
    rst_n = 1'b1; pwr_ok = 1'b1;
    chk(cyc + 1, 0, 0, 0, 0, 0, "off_en_low");
    repeat (2) tick();

    b = cyc + 1; en = 1'b1;
    chk(b,      0, 1, 0, 0, 0, "deb_enter");
    chk(b + 7,  0, 1, 0, 0, 0, "deb_last");
    chk(b + 8,  0, 2, 1, 0, 0, "ramp_d0");
    chk(b + 11, 0, 2, 1, 0, 0, "ramp_hold");
    chk(b + 12, 0, 2, 3, 0, 0, "ramp_d1");
    chk(b + 16, 0, 2, 7, 0, 0, "ramp_d2");
    chk(b + 19, 0, 2, 7, 0, 0, "ramp_wait");
    chk(b + 20, 0, 3, 7, 1, 0, "on");
    repeat (22) tick();

    t = cyc + 1; en = 1'b0;
    chk(t,      0, 4, 7, 0, 0, "down_enter");
    chk(t + 3,  0, 4, 7, 0, 0, "down_hold");
    chk(t + 4,  0, 4, 3, 0, 0, "down_d2");
    chk(t + 7,  0, 4, 3, 0, 0, "down_en_ignored");
    chk(t + 8,  0, 4, 1, 0, 0, "down_d1");
    chk(t + 12, 0, 0, 0, 0, 0, "down_off");
    chk(t + 13, 0, 0, 0, 0, 0, "off_stay");
    repeat (4) tick();
    en = 1'b1;
    repeat (6) tick();
    en = 1'b0;
    repeat (5) tick();

    b = cyc + 1; en = 1'b1;
    chk(b,      0, 1, 0, 0, 0, "glitch_deb");
    chk(b + 9,  0, 1, 0, 0, 0, "glitch_no_early_ramp");
    chk(b + 13, 0, 1, 0, 0, 0, "glitch_deb_last");
    chk(b + 14, 0, 2, 1, 0, 0, "glitch_ramp_d0");
    chk(b + 26, 0, 3, 7, 1, 0, "glitch_on");
    repeat (6) tick();
    pwr_ok = 1'b0;
    tick();
    pwr_ok = 1'b1;
    repeat (21) tick();

    f = cyc + 1; pwr_ok = 1'b0;
    chk(f,     0, 5, 0, 0, 1, "fault_enter");
    chk(f + 1, 0, 5, 0, 0, 1, "fault_clr_en1");
    chk(f + 2, 0, 5, 0, 0, 1, "fault_clr_en1_b");
    chk(f + 3, 0, 0, 0, 0, 0, "fault_cleared");
    tick();
    pwr_ok = 1'b1; clr = 1'b1;
    repeat (2) tick();
    en = 1'b0;
    tick();
    clr = 1'b0;
    tick();

    b = cyc + 1; en = 1'b1;
    chk(b + 20, 0, 3, 7, 1, 0, "on_again");
    repeat (21) tick();
    p = cyc + 1; en = 1'b0; pwr_ok = 1'b0;
    chk(p,     0, 5, 0, 0, 1, "fault_priority");
    chk(p + 1, 0, 0, 0, 0, 0, "fault_clr2");
    tick();
    pwr_ok = 1'b1; clr = 1'b1;
    tick();
    clr = 1'b0;
    tick();

    b = cyc + 1; en = 1'b1;
    chk(b + 12, 0, 2, 3, 0, 0, "pre_rst_ramp");
    chk(b + 13, 0, 0, 0, 0, 0, "async_rst");
    chk(b + 14, 0, 0, 0, 0, 0, "rst_held");
    repeat (14) tick();
    rst_n = 1'b0;
    #1;
    now_chk(0, 0, 0, 0, 0, "async_rst_now");
    tick();
    en = 1'b0;
    tick();
    rst_n = 1'b1;
    chk(cyc + 1, 0, 0, 0, 0, 0, "post_rst2_off");
    tick();

    b = cyc + 1; en2 = 1'b1;
    chk(b,     1, 1, 0, 0, 0, "fast_deb");
    chk(b + 1, 1, 2, 1, 0, 0, "fast_d0");
    chk(b + 2, 1, 2, 3, 0, 0, "fast_d1");
    chk(b + 3, 1, 2, 7, 0, 0, "fast_d2");
    chk(b + 4, 1, 3, 7, 1, 0, "fast_on");
    repeat (6) tick();

    done = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    fin = 1'b1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/pwrgood_sequencer.md
PWRGOOD_SEQUENCER -- requirements
Module: pwrgood_sequencer

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 8, meaning consecutive PWR_OK-high cycles required before ramp; legal range 1..256.
REQ-002 SHALL have parameter STAGE_DELAY, default 4, meaning cycles between successive domain enable/disable steps; legal range 1..256.
REQ-003 SHALL have port CLK  input  1  the single clock; all state changes occur on its rising edge.
REQ-004 SHALL have port RESET_B  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port EN  input  1  power-up request; 1 = sequence domains on, 0 = sequence them off.
REQ-006 SHALL have port PWR_OK  input  1  raw supply-good indication from the power-good cell; synchronous to CLK.
REQ-007 SHALL have port CLR_FAULT  input  1  fault clear request.
REQ-008 SHALL have port DOM_EN  output  3  per-domain enables; bit 0 powers up first and down last.
REQ-009 SHALL have port PG_X  output  1  all domains enabled and settled.
REQ-010 SHALL have port FAULT  output  1  sticky supply-loss flag.
REQ-011 SHALL have port STATE  output  3  current state encoding: OFF=0, DEBOUNCE=1, RAMP=2, ON=3, DOWN=4, FAULT=5.

Function
REQ-012 All outputs SHALL be registered; one internal 8-bit counter CNT SHALL be shared by all timed states and cleared on every state change.
REQ-013 OFF: DOM_EN=000, PG_X=0; EN=1 and PWR_OK=1 sampled -> DEBOUNCE; otherwise stay.
REQ-014 DEBOUNCE: EN=0 -> OFF; PWR_OK=0 -> stay, CNT=0; PWR_OK=1 with CNT<DEBOUNCE_CYCLES-1 -> CNT+1; PWR_OK=1 with CNT=DEBOUNCE_CYCLES-1 -> RAMP with DOM_EN=001 on the same edge.
REQ-015 RAMP: CNT increments each cycle; at CNT=STAGE_DELAY-1, DOM_EN SHALL shift in the next bit (001->011->111) with CNT=0, or, if DOM_EN=111, go to ON with PG_X=1.
REQ-016 ON: DOM_EN=111, PG_X=1; hold while EN=1 and PWR_OK=1.
REQ-017 EN=0 sampled in RAMP or ON SHALL go to DOWN with PG_X=0 on that edge, DOM_EN unchanged.
REQ-018 DOWN: CNT increments; at CNT=STAGE_DELAY-1, the highest set DOM_EN bit SHALL clear, with CNT=0; the edge that clears bit 0 SHALL also enter OFF; EN=1 during DOWN SHALL be ignored.
REQ-019 PWR_OK=0 sampled in RAMP, ON or DOWN SHALL, on that edge, enter FAULT with DOM_EN=000, PG_X=0, FAULT=1; this SHALL take priority over EN=0.
REQ-020 FAULT: outputs held (DOM_EN=000, PG_X=0, FAULT=1); CLR_FAULT=1 and EN=0 sampled together -> OFF with FAULT=0; CLR_FAULT with EN=1 SHALL be ignored.
REQ-021 PG_X=1 SHALL occur only when STATE=ON and DOM_EN=111.
REQ-022 Unused STATE encodings 6 and 7 SHALL recover to OFF on the next edge with all outputs 0.

Reset
REQ-023 RESET_B=0 SHALL immediately, without a clock, force STATE=OFF, DOM_EN=000, PG_X=0, FAULT=0, CNT=0, including mid-ramp or in FAULT.
REQ-024 After RESET_B rises, the first state evaluation SHALL be on the next CLK rising edge.

Verification
REQ-025 Defaults, PWR_OK=1, EN rises and is sampled at edge 0 -> DOM_EN[0] after edge 8, DOM_EN[1] after 12, DOM_EN[2] after 16, PG_X=1 after 20.
REQ-026 In ON, EN=0 sampled at edge t -> PG_X=0 at t, DOM_EN=011 at t+4, 001 at t+8, 000 and STATE=OFF at t+12.
REQ-027 In DEBOUNCE, PWR_OK pulses low for 1 cycle after 5 high cycles -> CNT restarts; DOM_EN[0] rises only after 8 further consecutive high cycles.
REQ-028 In ON, PWR_OK=0 for one cycle -> next edge DOM_EN=000, PG_X=0, FAULT=1, STATE=5; CLR_FAULT=1 with EN=1 -> no change; CLR_FAULT=1 with EN=0 -> STATE=0, FAULT=0.
REQ-029 RESET_B=0 asserted asynchronously with DOM_EN=011 -> all outputs 0 before the next CLK edge.
REQ-030 DEBOUNCE_CYCLES=1, STAGE_DELAY=1 -> DOM_EN=001, 011, 111 and PG_X on edges 1, 2, 3, 4 after the EN-sampling edge.
